// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serializes one ALU op at a time: operand drive, result capture, writeback.
// Owns a 4x4 register file and the architectural flag register.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_rs,
    input  logic [1:0] instr_rt,
    input  logic       instr_use_imm,
    input  logic [3:0] instr_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_mode,
    output logic       alu_carry_f,
    output logic       alu_borrow_f,
    input  logic [3:0] alu_c,
    input  logic [3:0] alu_flags,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [3:0] wb_data,
    output logic       wb_err,
    output logic [3:0] flags,
    input  logic [1:0] dbg_sel,
    output logic [3:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t     state_q, state_d;
    logic [3:0] rf_q [4];
    logic [3:0] flag_q, alu_a_q, alu_b_q, alu_mode_q, wb_data_q;
    logic [1:0] rd_q;
    logic       ill_q;

    always_comb begin
        state_d = state_q;
        instr_ready = state_q == IDLE;
        state_d = (state_q == IDLE) ? (instr_valid ? EXEC : IDLE) :
                  (state_q == EXEC) ? WB : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rf_q       <= '{default: '0};
            flag_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_mode_q <= '0;
            wb_data_q  <= '0;
            rd_q       <= '0;
            ill_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && instr_valid) begin
                alu_a_q    <= rf_q[instr_rs];
                alu_b_q    <= instr_use_imm ? instr_imm : rf_q[instr_rt];
                alu_mode_q <= instr_op;
                rd_q       <= instr_rd;
                ill_q      <= instr_op > 4'd10;
            end
            if (state_q == EXEC) begin
                wb_data_q <= ill_q ? 4'd0 : alu_c;
                if (!ill_q) begin
                    rf_q[rd_q]  <= alu_c;
                    flag_q[3:2] <= alu_flags[3:2];
                    // carry/borrow are architectural only for the chained ops
                    if (alu_mode_q == 4'd1) flag_q[0] <= alu_flags[0];
                    if (alu_mode_q == 4'd3) flag_q[1] <= alu_flags[1];
                end
            end
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_mode     = alu_mode_q;
    assign alu_carry_f  = flag_q[0];
    assign alu_borrow_f = flag_q[1];
    assign wb_valid     = state_q == WB;
    assign wb_rd        = rd_q;
    assign wb_data      = wb_data_q;
    assign wb_err       = ill_q;
    assign flags        = flag_q;
    assign dbg_data     = rf_q[dbg_sel];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a behavioural 4-bit ALU closing the loop.
module tb_alu_issue_ctrl;
    logic       clk = 0, rst = 1;
    logic       instr_valid = 0, instr_ready, instr_use_imm = 0;
    logic [3:0] instr_op = 0, instr_imm = 0;
    logic [1:0] instr_rd = 0, instr_rs = 0, instr_rt = 0, dbg_sel = 0;
    logic [3:0] alu_a, alu_b, alu_mode, alu_c, alu_flags, wb_data, flags, dbg_data;
    logic       alu_carry_f, alu_borrow_f, wb_valid, wb_err;
    logic [1:0] wb_rd;
    int         pass_cnt = 0, total_cnt = 0;
    logic       exec_rdy, exec_wb;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_use_imm(instr_use_imm), .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b),
        .alu_mode(alu_mode), .alu_carry_f(alu_carry_f), .alu_borrow_f(alu_borrow_f),
        .alu_c(alu_c), .alu_flags(alu_flags), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_err(wb_err), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: lt compares a against b plus incoming carry.
    logic [4:0] s;
    always_comb begin
        s = '0;
        case (alu_mode)
            4'd0:  s = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:  s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carry_f};
            4'd2:  s = {1'b0, alu_a} - {1'b0, alu_b};
            4'd3:  s = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_borrow_f};
            4'd4:  s = {2'b0, alu_a[3:1]};
            4'd5:  s = {1'b0, alu_a & alu_b};
            4'd6:  s = {1'b0, alu_a | alu_b};
            4'd7:  s = {1'b0, ~alu_a};
            4'd8:  s = {1'b0, alu_a ^ alu_b};
            4'd9:  s = {1'b0, ~(alu_a & alu_b)};
            4'd10: s = {1'b0, ~(alu_a | alu_b)};
            default: s = 5'h1f;
        endcase
        alu_c = s[3:0];
        alu_flags[3] = {1'b0, alu_a} < ({1'b0, alu_b} + {4'd0, alu_carry_f});
        alu_flags[2] = s[3:0] == 4'd0;
        alu_flags[1] = (alu_mode == 4'd2 || alu_mode == 4'd3) && s[4];
        alu_flags[0] = (alu_mode == 4'd0 || alu_mode == 4'd1) && s[4];
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        instr_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    // Issues one op; returns in the WB cycle with EXEC-cycle samples in exec_rdy/exec_wb.
    task automatic do_op(input logic [3:0] op, input logic [1:0] rd, rs, rt,
                         input logic ui, input logic [3:0] imm);
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        instr_use_imm = ui; instr_imm = imm; instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        instr_op = 4'hf; instr_rd = 2'd3; instr_imm = 4'h0;
        exec_rdy = instr_ready;
        exec_wb = wb_valid;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total_cnt++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", instr_ready); else pass_cnt++;
        total_cnt++; if ({wb_valid, wb_rd, wb_data, wb_err} !== 8'h00) $display("FAIL reset_wb got %h exp 00", {wb_valid, wb_rd, wb_data, wb_err}); else pass_cnt++;
        total_cnt++; if ({alu_a, alu_b, alu_mode, flags} !== 16'h0000) $display("FAIL reset_alu_flags got %h exp 0000", {alu_a, alu_b, alu_mode, flags}); else pass_cnt++;
    endtask

    task automatic test_or();
        apply_reset();
        do_op(4'd6, 2'd1, 2'd0, 2'd0, 1'b1, 4'd9);
        total_cnt++; if ({exec_rdy, exec_wb} !== 2'b00) $display("FAIL or_exec got rdy/wb %b exp 00", {exec_rdy, exec_wb}); else pass_cnt++;
        total_cnt++; if ({wb_valid, wb_rd, wb_data, wb_err} !== {1'b1, 2'd1, 4'd9, 1'b0}) $display("FAIL or_wb got %b_%h_%h_%b exp 1_1_9_0", wb_valid, wb_rd, wb_data, wb_err); else pass_cnt++;
        total_cnt++; if (flags !== 4'b1000) $display("FAIL or_flags got %b exp 1000", flags); else pass_cnt++;
        dbg_sel = 2'd1; #1;
        total_cnt++; if (dbg_data !== 4'd9) $display("FAIL or_dbg got %h exp 9", dbg_data); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({wb_valid, instr_ready} !== 2'b01) $display("FAIL or_after got wb/rdy %b exp 01", {wb_valid, instr_ready}); else pass_cnt++;
    endtask

    task automatic test_adc();
        do_op(4'd1, 2'd2, 2'd1, 2'd0, 1'b1, 4'd8);
        total_cnt++; if (wb_data !== 4'd1) $display("FAIL adc1_data got %h exp 1", wb_data); else pass_cnt++;
        total_cnt++; if (flags !== 4'b0001) $display("FAIL adc1_flags got %b exp 0001", flags); else pass_cnt++;
        @(negedge clk);
        do_op(4'd1, 2'd3, 2'd0, 2'd0, 1'b1, 4'd0);
        total_cnt++; if ({wb_rd, wb_data} !== {2'd3, 4'd1}) $display("FAIL adc2_data got %h/%h exp 3/1", wb_rd, wb_data); else pass_cnt++;
        total_cnt++; if (flags !== 4'b1000) $display("FAIL adc2_flags got %b exp 1000", flags); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_sbb();
        apply_reset();
        do_op(4'd3, 2'd1, 2'd0, 2'd0, 1'b1, 4'd1);
        total_cnt++; if (wb_data !== 4'hf) $display("FAIL sbb_data got %h exp f", wb_data); else pass_cnt++;
        total_cnt++; if (flags !== 4'b1010) $display("FAIL sbb_flags got %b exp 1010", flags); else pass_cnt++;
        @(negedge clk);
        do_op(4'd0, 2'd2, 2'd0, 2'd0, 1'b1, 4'd0);
        total_cnt++; if (wb_data !== 4'h0) $display("FAIL add_data got %h exp 0", wb_data); else pass_cnt++;
        total_cnt++; if (flags !== 4'b0110) $display("FAIL add_flags got %b exp 0110", flags); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3], imms [3], exp_d [3];
        logic [1:0] rds [3], rss [3];
        logic       uis [3];
        ops = '{4'd0, 4'd0, 4'd8}; rds = '{2'd1, 2'd2, 2'd3}; rss = '{2'd0, 2'd1, 2'd2};
        uis = '{1'b1, 1'b1, 1'b0}; imms = '{4'd3, 4'd4, 4'd0}; exp_d = '{4'd3, 4'd7, 4'd4};
        apply_reset();
        instr_valid = 1;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) begin
                instr_op = ops[i/3]; instr_rd = rds[i/3]; instr_rs = rss[i/3];
                instr_rt = 2'd1; instr_use_imm = uis[i/3]; instr_imm = imms[i/3];
            end
            total_cnt++; if ({instr_ready, wb_valid} !== {i % 3 == 0, i % 3 == 2}) $display("FAIL b2b_hs cyc %0d got rdy/wb %b exp %b", i, {instr_ready, wb_valid}, {i % 3 == 0, i % 3 == 2}); else pass_cnt++;
            if (i % 3 == 2) begin
                total_cnt++; if ({wb_rd, wb_data} !== {rds[i/3], exp_d[i/3]}) $display("FAIL b2b_wb op %0d got %h/%h exp %h/%h", i/3, wb_rd, wb_data, rds[i/3], exp_d[i/3]); else pass_cnt++;
            end
            @(negedge clk);
        end
        instr_valid = 0;
    endtask

    task automatic test_illegal();
        apply_reset();
        do_op(4'd6, 2'd2, 2'd0, 2'd0, 1'b1, 4'd5);
        @(negedge clk);
        do_op(4'b1100, 2'd2, 2'd2, 2'd2, 1'b1, 4'd7);
        total_cnt++; if ({wb_valid, wb_rd, wb_data, wb_err} !== {1'b1, 2'd2, 4'd0, 1'b1}) $display("FAIL ill_wb got %b_%h_%h_%b exp 1_2_0_1", wb_valid, wb_rd, wb_data, wb_err); else pass_cnt++;
        total_cnt++; if (flags !== 4'b1000) $display("FAIL ill_flags got %b exp 1000", flags); else pass_cnt++;
        dbg_sel = 2'd2; #1;
        total_cnt++; if (dbg_data !== 4'd5) $display("FAIL ill_reg got %h exp 5", dbg_data); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_exec();
        apply_reset();
        do_op(4'd6, 2'd1, 2'd0, 2'd0, 1'b1, 4'd6);
        @(negedge clk);
        instr_op = 4'd0; instr_rd = 2'd2; instr_rs = 2'd1; instr_use_imm = 1; instr_imm = 4'd1;
        instr_valid = 1;
        @(negedge clk);
        instr_valid = 0;
        rst = 1;
        @(negedge clk);
        total_cnt++; if (wb_valid !== 1'b0) $display("FAIL rexec_wb_in_rst got %b exp 0", wb_valid); else pass_cnt++;
        rst = 0;
        @(negedge clk);
        total_cnt++; if ({instr_ready, wb_valid, flags} !== 6'b100000) $display("FAIL rexec_state got rdy/wb/flags %b exp 100000", {instr_ready, wb_valid, flags}); else pass_cnt++;
        for (int r = 0; r < 4; r++) begin
            dbg_sel = r[1:0]; #1;
            total_cnt++; if (dbg_data !== 4'd0) $display("FAIL rexec_reg r%0d got %h exp 0", r, dbg_data); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_adc();
        test_sbb();
        test_back_to_back();
        test_illegal();
        test_reset_in_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/writeback controller that drives the 4-bit ALU's operand, mode and carry/borrow inputs and consumes its result and flags. It owns a 4-entry x 4-bit register file and the architectural flag register, and accepts one instruction at a time over a valid/ready handshake. The block sits between the instruction front-end and the combinational ALU. It serializes each operation through operand drive, result capture and writeback.

## Interface
- No parameters. Data width is fixed at 4 bits, with 4 registers.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept (high only in IDLE)
- instr_op  in  4  ALU mode
- instr_rd  in  2  destination register
- instr_rs  in  2  source register for operand a
- instr_rt  in  2  source register for operand b
- instr_use_imm  in  1  when 1, operand b = instr_imm
- instr_imm  in  4  immediate
- alu_a  out  4  registered operand a to ALU
- alu_b  out  4  registered operand b to ALU
- alu_mode  out  4  registered mode to ALU
- alu_carry_f  out  1  = flag_q[0]
- alu_borrow_f  out  1  = flag_q[1]
- alu_c  in  4  ALU result
- alu_flags  in  4  ALU flags {lt, zero, borrow, carry}
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  2  destination of completed op
- wb_data  out  4  result written
- wb_err  out  1  completed op had an illegal opcode
- flags  out  4  flag_q {lt, zero, borrow, carry}
- dbg_sel  in  2  debug register select
- dbg_data  out  4  combinational read of regfile[dbg_sel]

## Operation
- Mode map: 0000 ADD, 0001 ADC, 0010 SUB, 0011 SBB, 0100 SHR, 0101 AND, 0110 OR, 0111 NOT a, 1000 XOR, 1001 NAND, 1010 NOR. Opcodes 1011–1111 are illegal.
- FSM states:
  - IDLE -> EXEC on instr_valid && instr_ready.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- On accept:
  - alu_a <= regfile[rs].
  - alu_b <= use_imm ? imm : regfile[rt].
  - alu_mode <= op.
  - rd and the illegal bit are latched.
  - alu_a/b/mode hold their values until the next accept.
- End of EXEC, legal op: regfile[rd] <= alu_c, and wb_data <= alu_c.
- End of EXEC, flag update:
  - flag_q[3:2] <= alu_flags[3:2].
  - flag_q[0] <= alu_flags[0] only for ADC.
  - flag_q[1] <= alu_flags[1] only for SBB.
  - For all other modes, alu_flags[1:0] are ignored.
- End of EXEC, illegal op: no regfile write, no flag update, wb_data <= 0, wb_err latched 1.
- WB state: wb_valid = 1, with wb_rd, wb_data and wb_err valid.
- Hazards: none, because ops are fully serialized and each reads the regfile only at accept, after the prior writeback.

## Timing
- Reset values:
  - State IDLE, all regfile entries 0, flag_q 0.
  - alu_a, alu_b, alu_mode 0.
  - wb_valid 0, wb_rd 0, wb_data 0, wb_err 0.
  - instr_ready 1 once rst deasserts.
- Latency:
  - Accept edge at cycle N.
  - ALU inputs stable during cycle N+1 (EXEC); the ALU has a full cycle to settle.
  - Regfile and flags update at the N+2 edge.
  - wb_valid is high during cycle N+2.
- Throughput: one instruction per 3 cycles; instr_ready is low in EXEC and WB.
- dbg_data reflects a write in the cycle after the writing edge.
- Reset asserted in EXEC or WB: immediate return to IDLE, no wb_valid, regfile and flags cleared. The in-flight op is dropped.
- instr_* are sampled only on the accept edge and may change freely otherwise.

## Test plan
- Reset, then OR r1 = r0 | imm 9 -> wb_valid 2 cycles after accept, wb_rd=1, wb_data=9, flags=1000, dbg r1=9.
- With r1=9, ADC r2 = r1 + imm 8 -> wb_data=1, flags=0001. Then ADC r3 = r0 + imm 0 -> wb_data=1 (carry consumed), flags=1000.
- SBB r1 = r0 - imm 1 from reset -> wb_data=F, flags[1]=1. A following ADD r2 = r0 + imm 0 -> flags[1] still 1, flags[2]=1.
- instr_valid held high with 3 back-to-back ops -> accepts exactly every 3rd cycle, instr_ready low in EXEC/WB, 3 wb_valid pulses in order.
- Illegal op 1100 to r2 with r2=5 -> wb_valid with wb_err=1 and wb_data=0; r2 stays 5, flags unchanged.
- rst pulsed during EXEC -> no wb_valid, all regs and flags read 0, instr_ready=1 the cycle after release.
